// File: rtl/mem_port.sv
// mem_port: single-outstanding memory access sequencer between the core control FSM and a
// simple req/ack memory. It accepts one fetch, load or store strobe while idle. It holds the
// request stable until the memory acks or the wait counter times out, then pulses done.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   fetch_req/load_req/store_req one-cycle request strobes (priority fetch > store > load)
//   pc, daddr, wdata             fetch address, load/store address, store data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    memory request channel, stable while mem_req is high
//   mem_ack, mem_rdata           memory completion and read data
//   ir, inst                     instruction register and its decoded opcode/funct
//   mdr                          load result register
//   stall, done, err             busy indication, completion pulse, sticky timeout flag
module mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        load_req,
  input  logic        store_req,
  input  logic [31:0] pc,
  input  logic [31:0] daddr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [5:0]  inst,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;
  typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_t;

  // Counter value at which one more ack-less cycle means the access has timed out.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;
  logic        any_req;

  assign any_req = fetch_req | load_req | store_req;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAccess;
          cnt_d   = 8'd0;
          if (fetch_req) begin
            kind_d  = KindFetch;
            addr_d  = pc;
            wdata_d = 32'd0;
          end else if (store_req) begin
            kind_d  = KindStore;
            addr_d  = daddr;
            wdata_d = wdata;
          end else begin
            kind_d  = KindLoad;
            addr_d  = daddr;
            wdata_d = 32'd0;
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          // An ack in the final counted cycle still completes the access normally.
          if (kind_q == KindFetch) ir_d = mem_rdata;
          if (kind_q == KindLoad)  mdr_d = mem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CntLast) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      kind_q  <= KindFetch;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      ir_q    <= 32'd0;
      mdr_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == StAccess);
  assign mem_we    = mem_req & (kind_q == KindStore);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign err       = err_q;
  assign done      = (state_q == StDone);
  // Strobes must not raise stall while reset is holding the block idle.
  assign stall     = mem_req | ((state_q == StIdle) & any_req & ~reset);
  assign inst      = (ir_q[31:26] != 6'd0) ? ir_q[31:26] : ir_q[5:0];

endmodule

// File: tb/tb_mem_port.sv
module tb_mem_port;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, load_req, store_req;
  logic [31:0] pc, daddr, wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir, mdr;
  logic [5:0]  inst;
  logic        stall, done, err;

  mem_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .pc(pc), .daddr(daddr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .inst(inst), .mdr(mdr), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    int          nreq;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int nreq = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Monitor: checks the request channel every ACCESS cycle and the result on every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      nreq = 0;
    end else begin
      if (mem_req) begin
        nreq++;
        if (sb.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_we", mem_we, sb[0].we);
          chk("mem_wdata", mem_wdata, sb[0].wdata);
          chk("stall_access", stall, 1);
        end
      end
      if (done) begin
        chk("req_in_done", mem_req, 0);
        chk("stall_in_done", stall, 0);
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ir", ir, e.ir);
          chk("mdr", mdr, e.mdr);
          chk("err", err, e.err);
          chk("req_cycles", nreq, e.nreq);
        end
        nreq = 0;
      end
    end
  end

  // kind: 0 fetch, 1 load, 2 store, 3 fetch+store together. waits < 0 means never ack.
  task automatic access(input int kind, input logic [31:0] a_pc, input logic [31:0] a_daddr,
                        input logic [31:0] a_wdata, input int waits, input logic [31:0] rdata,
                        input bit inject, input logic [31:0] e_ir, input logic [31:0] e_mdr,
                        input logic e_err);
    exp_t e;
    int n;
    e.addr  = (kind == 1 || kind == 2) ? a_daddr : a_pc;
    e.we    = (kind == 2);
    e.wdata = (kind == 2) ? a_wdata : 32'd0;
    e.ir    = e_ir;
    e.mdr   = e_mdr;
    e.err   = e_err;
    e.nreq  = (waits < 0) ? TO : waits + 1;
    sb.push_back(e);
    pc = a_pc; daddr = a_daddr; wdata = a_wdata;
    fetch_req = (kind == 0 || kind == 3);
    store_req = (kind == 2 || kind == 3);
    load_req  = (kind == 1);
    #1;
    chk("stall_on_strobe", stall, 1);
    chk("req_on_strobe", mem_req, 0);
    @(posedge clk); #1;
    fetch_req = 0; store_req = 0; load_req = 0;
    chk("req_next_cycle", mem_req, 1);
    if (inject) begin
      load_req = 1;
      daddr = 32'h0000_0999;
    end
    if (waits >= 0) begin
      repeat (waits) begin
        @(posedge clk); #1;
        load_req = 0;
      end
      mem_ack = 1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 0; load_req = 0; mem_rdata = 32'hBAD0_BAD0;
      chk("done_after_ack", done, 1);
    end else begin
      n = 0;
      while (!done && n < 20) begin
        @(posedge clk); #1;
        load_req = 0;
        n++;
      end
      chk("timeout_done", done, 1);
      chk("timeout_cycles", n, TO);
    end
    @(posedge clk); #1;
    chk("done_one_pulse", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1; fetch_req = 0; load_req = 0; store_req = 0;
    pc = 0; daddr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    #12;
    chk("rst_ir", ir, 0); chk("rst_inst", inst, 0); chk("rst_mdr", mdr, 0);
    chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0); chk("rst_stall", stall, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    access(0, 32'h100, 32'h0, 32'h0, 3, 32'h2008_0005, 0, 32'h2008_0005, 32'h0, 0);
    chk("inst_opcode", inst, 6'b001000);
    access(1, 32'h0, 32'h40, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h2008_0005, 32'hDEAD_BEEF, 0);
    access(2, 32'h0, 32'h44, 32'h1234_5678, 2, 32'hFFFF_FFFF, 0,
           32'h2008_0005, 32'hDEAD_BEEF, 0);
    access(3, 32'h200, 32'h300, 32'h5555_AAAA, 1, 32'h0000_002A, 1,
           32'h0000_002A, 32'hDEAD_BEEF, 0);
    chk("inst_funct", inst, 6'h2A);

    // Ack while idle must not start or complete anything.
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("idle_ack_done", done, 0);
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_ir", ir, 32'h0000_002A);
    @(posedge clk); #1;

    access(1, 32'h0, 32'h80, 32'hAAAA_5555, -1, 32'h0, 0, 32'h0000_002A, 32'hDEAD_BEEF, 1);
    chk("err_sticky", err, 1);
    access(0, 32'h104, 32'h0, 32'h0, 0, 32'h8C22_0004, 0, 32'h8C22_0004, 32'hDEAD_BEEF, 1);
    chk("inst_lw", inst, 6'h23);
    chk("err_still", err, 1);

    // Reset in the middle of an access, between clock edges.
    e.addr = 32'h108; e.we = 0; e.wdata = 0; e.ir = 0; e.mdr = 0; e.err = 0; e.nreq = 0;
    sb.push_back(e);
    pc = 32'h108; fetch_req = 1;
    @(posedge clk); #1;
    fetch_req = 0;
    chk("mid_req", mem_req, 1);
    #2;
    reset = 1;
    #1;
    sb.delete();
    chk("mid_rst_req", mem_req, 0); chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_ir", ir, 0); chk("mid_rst_inst", inst, 0); chk("mid_rst_mdr", mdr, 0);
    chk("mid_rst_err", err, 0); chk("mid_rst_stall", stall, 0); chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    access(0, 32'h10C, 32'h0, 32'h0, 1, 32'h0000_0020, 0, 32'h0000_0020, 32'h0, 0);
    chk("inst_after_rst", inst, 6'h20);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
